// File: rtl/rx_iq_pkg.sv
// Shared types and defaults for the RX IQ sample FIFO.
package rx_iq_pkg;

    localparam int IQ_W_DEF       = 24;
    localparam int DEPTH_LOG2_DEF = 9;

    typedef struct packed {
        logic signed [IQ_W_DEF-1:0] rx1_i;
        logic signed [IQ_W_DEF-1:0] rx1_q;
        logic signed [IQ_W_DEF-1:0] rx2_i;
        logic signed [IQ_W_DEF-1:0] rx2_q;
    } iq_set_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PRIME = 2'd1,
        VALID = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/rx_iq_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module rx_iq_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 96
) (
    input  logic              clk_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Write port
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port, no reset so it maps onto block RAM
    always_ff @(posedge clk_in) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/rx_iq_fifo.sv
// rx_iq_fifo: first-word-fall-through buffer for decimated RX IQ sample sets.
// Define RX_IQ_FIFO_RX2_EN to store the RX2 channel; otherwise rx2_i/rx2_q read as zero.
module rx_iq_fifo
    import rx_iq_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int IQ_W       = IQ_W_DEF
) (
    input  logic                clk_in,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [IQ_W-1:0]     in_rx1_i,
    input  logic [IQ_W-1:0]     in_rx1_q,
    input  logic [IQ_W-1:0]     in_rx2_i,
    input  logic [IQ_W-1:0]     in_rx2_q,
    input  logic                read_req,
    input  logic                read_clk,
    input  logic                flags_clr,
    output logic [IQ_W-1:0]     rx1_i,
    output logic [IQ_W-1:0]     rx1_q,
    output logic [IQ_W-1:0]     rx2_i,
    output logic [IQ_W-1:0]     rx2_q,
    output logic [DEPTH_LOG2:0] fill_level,
    output logic                overrun,
    output logic                underrun
);

    localparam int LVL_W = DEPTH_LOG2 + 1;
`ifdef RX_IQ_FIFO_RX2_EN
    localparam int SET_W = 4 * IQ_W;
`else
    localparam int SET_W = 2 * IQ_W;
`endif
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]      LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0]      LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    fifo_state_t           state_r, next_state_s;
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]      level_r, ram_cnt_s;
    logic                  read_clk_d_r;
    logic                  pop_s, pop_ok_s, pop_bad_s, full_s;
    logic                  wr_ok_s, wr_drop_s, ram_avail_s, rd_en_s, head_load_s;
    logic [SET_W-1:0]      wr_data_s, rd_data_s;

`ifdef RX_IQ_FIFO_RX2_EN
    assign wr_data_s = {in_rx1_i, in_rx1_q, in_rx2_i, in_rx2_q};
`else
    logic unused_rx2_s;
    assign wr_data_s   = {in_rx1_i, in_rx1_q};
    assign unused_rx2_s = ^{in_rx2_i, in_rx2_q};
`endif

    // The set being primed has already left the RAM but still counts in the level
    assign ram_cnt_s   = (state_r == EMPTY) ? level_r : (level_r - LVL_ONE);
    assign ram_avail_s = (ram_cnt_s != {LVL_W{1'b0}});
    assign full_s      = (level_r == LVL_FULL);
    assign pop_s       = read_req & read_clk & ~read_clk_d_r;
    assign wr_ok_s     = read_req & in_valid & (~full_s | pop_ok_s);
    assign wr_drop_s   = read_req & in_valid & full_s & ~pop_ok_s;
    assign fill_level  = level_r;

    rx_iq_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (SET_W)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (rd_ptr_r),
        .rd_data (rd_data_s)
    );

    // Head state register and read_clk edge-detect delay
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= EMPTY;
            read_clk_d_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            read_clk_d_r <= read_clk;
        end
    end

    // Next-state, RAM read issue and pop classification
    always_comb begin
        next_state_s = state_r;
        rd_en_s      = 1'b0;
        head_load_s  = 1'b0;
        pop_ok_s     = 1'b0;
        pop_bad_s    = 1'b0;
        if (!read_req) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    pop_bad_s = pop_s;
                    if (ram_avail_s) begin
                        rd_en_s      = 1'b1;
                        next_state_s = PRIME;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                PRIME: begin
                    pop_bad_s    = pop_s;
                    head_load_s  = 1'b1;
                    next_state_s = VALID;
                end
                VALID: begin
                    if (pop_s) begin
                        pop_ok_s = 1'b1;
                        if (ram_avail_s) begin
                            rd_en_s      = 1'b1;
                            next_state_s = PRIME;
                        end else begin
                            next_state_s = EMPTY;
                        end
                    end else begin
                        next_state_s = VALID;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // Pointers and fill level; read_req low flushes everything
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else if (!read_req) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // RX1 head registers; they hold the last popped set while empty
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx1_i <= {IQ_W{1'b0}};
            rx1_q <= {IQ_W{1'b0}};
        end else if (head_load_s) begin
            rx1_i <= rd_data_s[SET_W-1 -: IQ_W];
            rx1_q <= rd_data_s[SET_W-IQ_W-1 -: IQ_W];
        end
    end

`ifdef RX_IQ_FIFO_RX2_EN
    // RX2 head registers
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            rx2_i <= {IQ_W{1'b0}};
            rx2_q <= {IQ_W{1'b0}};
        end else if (head_load_s) begin
            rx2_i <= rd_data_s[2*IQ_W-1 -: IQ_W];
            rx2_q <= rd_data_s[IQ_W-1:0];
        end
    end
`else
    assign rx2_i = {IQ_W{1'b0}};
    assign rx2_q = {IQ_W{1'b0}};
`endif

    // Sticky error flags; a new event beats a coincident clear
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= wr_drop_s | (overrun  & ~flags_clr);
            underrun <= pop_bad_s | (underrun & ~flags_clr);
        end
    end

endmodule
